// File: rtl/cpu_pc_monitor_shared_pkg.sv
// Types shared by the CPU PC monitor producer (XRTL) and its HVL consumer.
// Trigger entries, the trigger buffer loaded from HVL, and the captured record.
package cpu_pc_monitor_shared_pkg;

  localparam int CPU_PC_NUMBER_OF_TRIGGERS = 8;
  localparam int CPU_PC_COUNTER_SIZE       = 32;
  localparam int CPU_PC_FIFO_DEPTH         = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_trigger;
  } packed_pc_trigger_s;

  typedef packed_pc_trigger_s packed_pc_trigger_t;

  typedef packed_pc_trigger_t [CPU_PC_NUMBER_OF_TRIGGERS-1:0] packed_pc_trigger_buf_t;

  typedef struct packed {
    logic [31:0]                    r1;
    logic [31:0]                    r2;
    logic [31:0]                    r3;
    logic [31:0]                    r4;
    logic [31:0]                    r5;
    logic [CPU_PC_COUNTER_SIZE-1:0] clock_count;
    logic [31:0]                    pc;
  } packed_pc_monitor_s;

  typedef packed_pc_monitor_s packed_pc_monitor_t;

  // True when any valid entry holds exactly this PC; invalid entries never match.
  function automatic bit pc_hit(packed_pc_trigger_buf_t trig_tbl, bit [31:0] pc_in);
    pc_hit = 1'b0;
    for (int i = 0; i < CPU_PC_NUMBER_OF_TRIGGERS; i++) begin
      if (trig_tbl[i].valid && (trig_tbl[i].pc_trigger == pc_in)) begin
        pc_hit = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/cpu_pc_record_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is visible while not empty.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module cpu_pc_record_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign level   = level_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so stale storage never leaks out.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/cpu_pc_trigger_capture.sv
// Compares every retired PC against the HVL-loaded trigger table and queues a
// {r1..r5, cycle stamp, pc} record on a hit for the downstream transactor.
module cpu_pc_trigger_capture
  import cpu_pc_monitor_shared_pkg::*;
#(
  parameter int NUM_TRIGGERS = CPU_PC_NUMBER_OF_TRIGGERS,
  parameter int COUNTER_SIZE = CPU_PC_COUNTER_SIZE,
  parameter int FIFO_DEPTH   = CPU_PC_FIFO_DEPTH,
  parameter int OVF_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                trig_load,
  input  packed_pc_trigger_t [NUM_TRIGGERS-1:0] trig_buf,
  input  logic                                trig_clear,
  input  logic                                pc_valid,
  input  logic [31:0]                         pc,
  input  logic [31:0]                         r1,
  input  logic [31:0]                         r2,
  input  logic [31:0]                         r3,
  input  logic [31:0]                         r4,
  input  logic [31:0]                         r5,
  output logic                                rec_valid,
  output packed_pc_monitor_t                  rec_data,
  input  logic                                rec_ready,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic [OVF_WIDTH-1:0]                ovf_count,
  output logic                                armed
);

  localparam int REC_W = $bits(packed_pc_monitor_t);

  logic [1:0]               rst_sync_reg;
  logic                     srst_n;
  packed_pc_trigger_buf_t   table_view;
  logic [COUNTER_SIZE-1:0]  cnt_reg;
  logic                     s1_valid_reg;
  logic                     s1_match_reg;
  packed_pc_monitor_t       s1_rec_reg;
  packed_pc_monitor_t       s1_rec_next;
  logic                     hit;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     drop;
  logic [REC_W-1:0]         head_data;
  logic [OVF_WIDTH-1:0]     ovf_count_reg;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end
  assign srst_n = rst_sync_reg[1];

  // NUM_TRIGGERS must not exceed the buffer size; unused slots read as invalid.
  genvar gi;
  generate
    for (gi = 0; gi < CPU_PC_NUMBER_OF_TRIGGERS; gi++) begin : g_tbl
      if (gi < NUM_TRIGGERS) begin : g_live
        packed_pc_trigger_t entry_reg;
        always_ff @(posedge clk or negedge srst_n) begin
          if (!srst_n) begin
            entry_reg <= '0;
          end else if (trig_clear) begin
            entry_reg.valid <= 1'b0;
          end else if (trig_load) begin
            entry_reg <= trig_buf[gi];
          end
        end
        assign table_view[gi] = entry_reg;
      end else begin : g_pad
        assign table_view[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    armed = 1'b0;
    for (int i = 0; i < CPU_PC_NUMBER_OF_TRIGGERS; i++) begin
      armed = armed | table_view[i].valid;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + COUNTER_SIZE'(1);
    end
  end

  always_comb begin
    s1_rec_next             = '0;
    s1_rec_next.r1          = r1;
    s1_rec_next.r2          = r2;
    s1_rec_next.r3          = r3;
    s1_rec_next.r4          = r4;
    s1_rec_next.r5          = r5;
    s1_rec_next.clock_count = CPU_PC_COUNTER_SIZE'(cnt_reg);
    s1_rec_next.pc          = pc;
  end

  // The match is taken against the table as it stands in the PC's own cycle,
  // so a same-cycle load or clear only affects later compares.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      s1_valid_reg <= 1'b0;
      s1_match_reg <= 1'b0;
      s1_rec_reg   <= '0;
    end else begin
      s1_valid_reg <= pc_valid && enable;
      s1_match_reg <= pc_hit(table_view, pc);
      if (pc_valid && enable) begin
        s1_rec_reg <= s1_rec_next;
      end
    end
  end

  assign hit  = s1_valid_reg && s1_match_reg;
  assign pop  = rec_valid && rec_ready;
  assign drop = hit && fifo_full && !pop;

  cpu_pc_record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (srst_n),
    .push      (hit),
    .push_data (s1_rec_reg),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign rec_valid = !fifo_empty;
  assign rec_data  = head_data;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      ovf_count_reg <= '0;
    end else if (drop && (ovf_count_reg != '1)) begin
      ovf_count_reg <= ovf_count_reg + OVF_WIDTH'(1);
    end
  end
  assign ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_cpu_pc_trigger_capture.sv
// Scoreboard bench: a cycle-level reference model predicts accepted records,
// occupancy and drops; a monitor compares whatever the DUT presents.
module tb_cpu_pc_trigger_capture;
  import cpu_pc_monitor_shared_pkg::*;

  localparam int NT    = 8;
  localparam int CS    = 8;
  localparam int DEPTH = 4;
  localparam int SBN   = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic trig_load = 1'b0;
  logic trig_clear = 1'b0;
  packed_pc_trigger_t [NT-1:0] trig_buf = '0;
  logic pc_valid = 1'b0;
  logic [31:0] pc = '0, r1 = '0, r2 = '0, r3 = '0, r4 = '0, r5 = '0;
  logic rec_valid;
  packed_pc_monitor_t rec_data;
  logic rec_ready = 1'b1;
  logic [2:0] fifo_level;
  logic [15:0] ovf_count;
  logic armed;

  cpu_pc_trigger_capture #(
    .NUM_TRIGGERS (NT),
    .COUNTER_SIZE (CS),
    .FIFO_DEPTH   (DEPTH),
    .OVF_WIDTH    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .trig_load  (trig_load),
    .trig_buf   (trig_buf),
    .trig_clear (trig_clear),
    .pc_valid   (pc_valid),
    .pc         (pc),
    .r1         (r1),
    .r2         (r2),
    .r3         (r3),
    .r4         (r4),
    .r5         (r5),
    .rec_valid  (rec_valid),
    .rec_data   (rec_data),
    .rec_ready  (rec_ready),
    .fifo_level (fifo_level),
    .ovf_count  (ovf_count),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  // Reference model state (written by the driver only).
  bit                 tv [NT];
  bit [31:0]          tp [NT];
  int                 mdl_cnt = 0;
  int                 mdl_level = 0;
  int                 mdl_ovf = 0;
  bit                 pend_valid = 1'b0;
  packed_pc_monitor_t pend_rec;
  bit                 mdl_on = 1'b0;
  packed_pc_monitor_t sb_mem [SBN];
  int                 sb_wr = 0;
  bit                 final_chk = 1'b0;

  // Written by the monitor only.
  int n_cmp = 0;
  int n_bad = 0;
  int sb_rd = 0;

  function automatic bit mdl_armed();
    mdl_armed = 1'b0;
    for (int i = 0; i < NT; i++) if (tv[i]) mdl_armed = 1'b1;
  endfunction

  // One clock edge of the spec: stage-2 result enters the FIFO (or is dropped),
  // the head leaves on a handshake, then this cycle's PC is matched.
  task automatic model_edge();
    bit do_pop;
    bit match;
    do_pop = (mdl_level > 0) && rec_ready;
    if (pend_valid) begin
      if (mdl_level < DEPTH || do_pop) begin
        sb_mem[sb_wr % SBN] = pend_rec;
        sb_wr++;
        mdl_level++;
      end else if (mdl_ovf != 16'hFFFF) begin
        mdl_ovf++;
      end
    end
    if (do_pop) mdl_level--;
    match = 1'b0;
    for (int i = 0; i < NT; i++) if (tv[i] && tp[i] == pc) match = 1'b1;
    pend_valid = pc_valid && enable && match;
    pend_rec = '{r1: r1, r2: r2, r3: r3, r4: r4, r5: r5, clock_count: 32'(mdl_cnt), pc: pc};
    if (enable) mdl_cnt = (mdl_cnt + 1) % 256;
    if (trig_clear) begin
      for (int i = 0; i < NT; i++) tv[i] = 1'b0;
    end else if (trig_load) begin
      for (int i = 0; i < NT; i++) begin
        tv[i] = trig_buf[i].valid;
        tp[i] = trig_buf[i].pc_trigger;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      tv[i] = 1'b0;
      tp[i] = '0;
    end
    mdl_cnt = 0;
    mdl_level = 0;
    mdl_ovf = 0;
    pend_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (mdl_on) model_edge();
    #1;
    trig_load = 1'b0;
    trig_clear = 1'b0;
    pc_valid = 1'b0;
  endtask

  task automatic load_one(int idx, bit v, logic [31:0] p);
    trig_buf = '0;
    trig_buf[idx] = '{valid: v, pc_trigger: p};
    trig_load = 1'b1;
  endtask

  task automatic drive_pc(logic [31:0] p);
    pc_valid = 1'b1;
    pc = p;
    r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom; r5 = $urandom;
  endtask

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        sb_rd = sb_wr;
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_rec_data", rec_data, 0);
        chk("rst_ovf_count", ovf_count, 0);
        chk("rst_armed", armed, 0);
      end else begin
        chk("rec_valid", rec_valid, mdl_level > 0);
        chk("fifo_level", fifo_level, mdl_level);
        chk("ovf_count", ovf_count, mdl_ovf);
        chk("armed", armed, mdl_armed());
        if (rec_valid) begin
          if (sb_rd < sb_wr) begin
            chk("rec_data", rec_data, sb_mem[sb_rd % SBN]);
            if (rec_ready) sb_rd++;
          end else begin
            chk("rec_unexpected", rec_valid, 0);
          end
        end
        if (final_chk) chk("sb_drained", sb_rd, sb_wr);
      end
    end
  end

  // Driver.
  initial begin
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    mdl_on = 1'b1;
    repeat (3) tick();

    // First hit at stamp 10 with r1..r5 = 1..5.
    enable = 1'b1;
    load_one(0, 1'b1, 32'h1000);
    tick();
    while (mdl_cnt != 10) tick();
    pc_valid = 1'b1; pc = 32'h1000;
    r1 = 1; r2 = 2; r3 = 3; r4 = 4; r5 = 5;
    tick();
    repeat (4) tick();

    // Invalid entry never matches; two matching entries give one record.
    load_one(0, 1'b0, 32'h2000);
    tick();
    drive_pc(32'h2000);
    tick();
    repeat (3) tick();
    trig_buf = '0;
    trig_buf[3] = '{valid: 1'b1, pc_trigger: 32'h3000};
    trig_buf[5] = '{valid: 1'b1, pc_trigger: 32'h3000};
    trig_load = 1'b1;
    tick();
    drive_pc(32'h3000);
    tick();
    repeat (4) tick();

    // Overflow: six hits with no consumer.
    rec_ready = 1'b0;
    load_one(0, 1'b1, 32'h6000);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_pc(32'h6000);
      tick();
    end
    repeat (4) tick();
    // Hit reaching a full FIFO in the same cycle as a pop.
    drive_pc(32'h6000);
    tick();
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    repeat (3) tick();
    rec_ready = 1'b1;
    repeat (6) tick();

    // Same-cycle load does not affect that compare; clear beats load.
    load_one(0, 1'b1, 32'h4000);
    drive_pc(32'h4000);
    tick();
    drive_pc(32'h4000);
    tick();
    repeat (3) tick();
    load_one(1, 1'b1, 32'h4100);
    trig_clear = 1'b1;
    tick();
    repeat (2) tick();

    // Stamp wrap: hits at counter 255 and 0.
    load_one(2, 1'b1, 32'h5000);
    tick();
    while (mdl_cnt != 255) tick();
    drive_pc(32'h5000);
    tick();
    drive_pc(32'h5000);
    tick();
    repeat (4) tick();

    // Mid-stream reset with two records queued.
    rec_ready = 1'b0;
    load_one(0, 1'b1, 32'h7000);
    tick();
    drive_pc(32'h7000);
    tick();
    drive_pc(32'h7000);
    tick();
    repeat (3) tick();
    rst_n = 1'b0;
    enable = 1'b0;
    mdl_on = 1'b0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    mdl_on = 1'b1;
    rec_ready = 1'b1;
    repeat (3) tick();

    // Randomized traffic over a small PC pool.
    for (int c = 0; c < 500; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      rec_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < NT; i++) begin
          trig_buf[i] = '{valid: 1'($urandom_range(0, 1)),
                          pc_trigger: 32'($urandom_range(1, 5)) << 12};
        end
        trig_load = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) trig_clear = 1'b1;
      if ($urandom_range(0, 3) != 0) drive_pc(32'($urandom_range(1, 5)) << 12);
      tick();
    end

    // Drain and confirm every predicted record was seen.
    pc_valid = 1'b0;
    enable = 1'b0;
    rec_ready = 1'b1;
    repeat (8) tick();
    final_chk = 1'b1;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
